// File: rtl/ddr_rd_burst_responder.sv
// Memory-side DDR read-burst responder: first beat RD_LATENCY+1 cycles after acceptance, then one finish pulse.
// No backpressure: beats stream back-to-back once started; req is ignored outside IDLE.
module ddr_rd_burst_responder #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_SIZE  = 32,
  parameter int LEN_WIDTH  = 10,
  parameter int MEM_DEPTH  = 1024,
  parameter int RD_LATENCY = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                         s_clk,
  input  logic                         s_rst,
  input  logic                         rd_burst_req,
  input  logic [ADDR_SIZE-1:0]         rd_burst_addr,
  input  logic [LEN_WIDTH-1:0]         rd_burst_len,
  output logic [DATA_WIDTH-1:0]        rd_burst_data,
  output logic                         rd_burst_valid,
  output logic                         rd_burst_finish,
  input  logic                         init_wr_en,
  input  logic [$clog2(MEM_DEPTH)-1:0] init_wr_addr,
  input  logic [DATA_WIDTH-1:0]        init_wr_data,
  output logic                         o_busy,
  output logic [31:0]                  o_burst_cnt
);

  localparam int IDX_W   = $clog2(MEM_DEPTH);
  localparam int BSH     = $clog2(DATA_WIDTH / 8);
  localparam int CNT_MAX = (RD_LATENCY > GAP_CYCLES) ? RD_LATENCY : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, LAT, BURST, FIN, GAP} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  finish_q, finish_d;
  logic                  busy_q, busy_d;
  logic [31:0]           burst_cnt_q, burst_cnt_d;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] mem_rd_q;
  logic                  addr_unused;

  // Only the word-index slice of the byte address matters.
  assign addr_unused = ^rd_burst_addr;

  // Read-first RAM: the read address runs one beat ahead of the data register.
  always_ff @(posedge s_clk) begin
    if (init_wr_en) begin
      mem[init_wr_addr] <= init_wr_data;
    end
    mem_rd_q <= mem[idx_q];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    rem_d       = rem_q;
    data_d      = '0;
    valid_d     = 1'b0;
    finish_d    = 1'b0;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (rd_burst_req) begin
          idx_d   = rd_burst_addr[BSH +: IDX_W];
          rem_d   = rd_burst_len;
          cnt_d   = CNT_W'(RD_LATENCY - 1);
          state_d = LAT;
        end
      end
      LAT: begin
        if (cnt_q == '0) begin
          if (rem_q != '0) begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = BURST;
          end else begin
            state_d = FIN;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      BURST: begin
        valid_d = 1'b1;
        data_d  = mem_rd_q;
        idx_d   = idx_q + IDX_W'(1);
        rem_d   = rem_q - LEN_WIDTH'(1);
        if (rem_q == LEN_WIDTH'(1)) begin
          state_d = FIN;
        end
      end
      FIN: begin
        finish_d    = 1'b1;
        burst_cnt_d = burst_cnt_q + 32'd1;
        cnt_d       = CNT_W'(GAP_CYCLES - 1);
        state_d     = GAP;
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      rem_q       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      finish_q    <= 1'b0;
      busy_q      <= 1'b0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      rem_q       <= rem_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      finish_q    <= finish_d;
      busy_q      <= busy_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign rd_burst_data   = data_q;
  assign rd_burst_valid  = valid_q;
  assign rd_burst_finish = finish_q;
  assign o_busy          = busy_q;
  assign o_burst_cnt     = burst_cnt_q;

endmodule
